// File: rtl/ap_ctrl_stats_monitor.sv
// N-channel ap_ctrl_hs / ap_ctrl_chain handshake monitor with per-channel
// transaction, latency and stall statistics plus sticky timeout / protocol flags.
module ap_ctrl_stats_monitor #(
  parameter int unsigned    N_CH       = 4,
  parameter int unsigned    CNT_W      = 32,
  parameter int unsigned    TIMEOUT    = 65535,
  parameter logic [N_CH-1:0] CHAIN_MASK = '0,
  localparam int unsigned   SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             finish,
  input  logic [N_CH-1:0]  ch_ap_start,
  input  logic [N_CH-1:0]  ch_ap_ready,
  input  logic [N_CH-1:0]  ch_ap_done,
  input  logic [N_CH-1:0]  ch_ap_continue,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic [2:0]       rd_field,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  timeout,
  output logic [N_CH-1:0]  proto_err,
  output logic             all_idle,
  output logic             finished
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE_WAIT} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT - 1);

  state_t           state     [N_CH];
  state_t           state_nxt [N_CH];
  logic [CNT_W-1:0] lat       [N_CH];
  logic [CNT_W-1:0] lat_nxt   [N_CH];
  logic [CNT_W-1:0] rec_lat   [N_CH];
  logic [CNT_W-1:0] txn_cnt   [N_CH];
  logic [CNT_W-1:0] last_lat  [N_CH];
  logic [CNT_W-1:0] min_lat   [N_CH];
  logic [CNT_W-1:0] max_lat   [N_CH];
  logic [CNT_W-1:0] stall_cnt [N_CH];
  logic [N_CH-1:0]  rec, stall_ev, to_ev, pe_ev, cont_eff;
  logic [CNT_W-1:0] rd_nxt;
  logic             finish_seen;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Non-chain channels behave as if ap_continue were tied high.
  assign cont_eff = ~CHAIN_MASK | ch_ap_continue;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state[i] <= IDLE;
        lat[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state[i] <= state_nxt[i];
        lat[i]   <= lat_nxt[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_nxt[i] = state[i];
      lat_nxt[i]   = lat[i];
      rec[i]       = 1'b0;
      rec_lat[i]   = '0;
      stall_ev[i]  = 1'b0;
      to_ev[i]     = 1'b0;
      pe_ev[i]     = 1'b0;
      unique case (state[i])
        IDLE: begin
          if (ch_ap_start[i]) begin
            lat_nxt[i] = '0;
            if (ch_ap_done[i]) rec[i] = 1'b1;
            else               state_nxt[i] = BUSY;
          end else if (ch_ap_done[i] || ch_ap_ready[i]) begin
            pe_ev[i] = 1'b1;
          end
        end
        BUSY: begin
          lat_nxt[i] = sat_inc(lat[i]);
          to_ev[i]   = (lat[i] == TO_VAL);
          if (ch_ap_done[i]) begin
            rec[i]       = 1'b1;
            rec_lat[i]   = sat_inc(lat[i]);
            state_nxt[i] = cont_eff[i] ? IDLE : DONE_WAIT;
          end
        end
        DONE_WAIT: begin
          pe_ev[i] = ch_ap_done[i];
          if (cont_eff[i]) state_nxt[i] = IDLE;
          else             stall_ev[i]  = 1'b1;
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < N_CH; i++) busy[i] = (state[i] != IDLE);
    all_idle = ~|busy;
  end

  // clear wipes statistics only; the FSMs and latency counters keep running.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        txn_cnt[i]   <= '0;
        last_lat[i]  <= '0;
        min_lat[i]   <= '1;
        max_lat[i]   <= '0;
        stall_cnt[i] <= '0;
      end
      timeout   <= '0;
      proto_err <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        txn_cnt[i]   <= '0;
        last_lat[i]  <= '0;
        min_lat[i]   <= '1;
        max_lat[i]   <= '0;
        stall_cnt[i] <= '0;
      end
      timeout   <= '0;
      proto_err <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (rec[i]) begin
          txn_cnt[i]  <= sat_inc(txn_cnt[i]);
          last_lat[i] <= rec_lat[i];
          if (rec_lat[i] < min_lat[i]) min_lat[i] <= rec_lat[i];
          if (rec_lat[i] > max_lat[i]) max_lat[i] <= rec_lat[i];
        end
        if (stall_ev[i]) stall_cnt[i] <= sat_inc(stall_cnt[i]);
        if (to_ev[i])    timeout[i]   <= 1'b1;
        if (pe_ev[i])    proto_err[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        case (rd_field)
          3'd0:    rd_nxt = txn_cnt[i];
          3'd1:    rd_nxt = last_lat[i];
          3'd2:    rd_nxt = min_lat[i];
          3'd3:    rd_nxt = max_lat[i];
          3'd4:    rd_nxt = stall_cnt[i];
          3'd5:    rd_nxt = CNT_W'({proto_err[i], timeout[i], busy[i]});
          default: rd_nxt = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data     <= '0;
      finish_seen <= 1'b0;
      finished    <= 1'b0;
    end else begin
      rd_data <= rd_nxt;
      if (finish) finish_seen <= 1'b1;
      finished <= finish_seen && all_idle;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_stats_monitor.sv
// Directed bench for ap_ctrl_stats_monitor: 4 channels, ch1 chained, TIMEOUT=16.
module tb_ap_ctrl_stats_monitor;

  logic        clock, reset, clear, finish;
  logic [3:0]  ch_ap_start, ch_ap_ready, ch_ap_done, ch_ap_continue;
  logic [1:0]  rd_sel;
  logic [2:0]  rd_field;
  logic [31:0] rd_data;
  logic [3:0]  busy, timeout, proto_err;
  logic        all_idle, finished;
  int          n_vec = 0;
  int          n_err = 0;
  int          bcnt;
  logic [31:0] v;

  ap_ctrl_stats_monitor #(
    .N_CH(4), .CNT_W(32), .TIMEOUT(16), .CHAIN_MASK(4'b0010)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .finish(finish),
    .ch_ap_start(ch_ap_start), .ch_ap_ready(ch_ap_ready),
    .ch_ap_done(ch_ap_done), .ch_ap_continue(ch_ap_continue),
    .rd_sel(rd_sel), .rd_field(rd_field), .rd_data(rd_data),
    .busy(busy), .timeout(timeout), .proto_err(proto_err),
    .all_idle(all_idle), .finished(finished)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input int ch, input int f, output logic [31:0] d);
    rd_sel   = 2'(ch);
    rd_field = 3'(f);
    tick();
    d = rd_data;
  endtask

  // start at edge t, done sampled at edge t+lat (lat>=1)
  task automatic run_txn(input int ch, input int lat);
    ch_ap_start[ch] = 1'b1;
    tick();
    ch_ap_start[ch] = 1'b0;
    repeat (lat - 1) tick();
    ch_ap_done[ch] = 1'b1;
    tick();
    ch_ap_done[ch] = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; finish = 1'b0;
    ch_ap_start = '0; ch_ap_ready = '0; ch_ap_done = '0; ch_ap_continue = 4'hF;
    rd_sel = '0; rd_field = '0;
    tick(); tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_all_idle", 32'(all_idle), 1);
    chk("rst_finished", 32'(finished), 0);
    reset = 1'b1;
    rd(0, 2, v); chk("rst_min_lat", v, 32'hFFFF_FFFF);

    // single hs transaction, latency 7
    ch_ap_start[0] = 1'b1;
    tick();
    ch_ap_start[0] = 1'b0;
    bcnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (busy[0]) bcnt++;
      if (k == 6) ch_ap_done[0] = 1'b1;
      else tick();
    end
    tick();
    ch_ap_done[0] = 1'b0;
    chk("t1_busy_cycles", 32'(bcnt), 7);
    chk("t1_busy_after", 32'(busy[0]), 0);
    rd(0, 0, v); chk("t1_txn", v, 1);
    rd(0, 1, v); chk("t1_last", v, 7);
    rd(0, 2, v); chk("t1_min", v, 7);
    rd(0, 3, v); chk("t1_max", v, 7);
    rd(0, 4, v); chk("t1_stall", v, 0);

    // chained channel held in DONE_WAIT for 3 cycles
    ch_ap_continue[1] = 1'b0;
    run_txn(1, 3);
    chk("t2_dw_busy", 32'(busy[1]), 1);
    repeat (3) tick();
    chk("t2_dw_busy3", 32'(busy[1]), 1);
    ch_ap_continue[1] = 1'b1;
    tick();
    chk("t2_idle", 32'(busy[1]), 0);
    rd(1, 4, v); chk("t2_stall", v, 3);
    rd(1, 1, v); chk("t2_last", v, 3);

    // min/max tracking, then clear
    run_txn(2, 5); run_txn(2, 2); run_txn(2, 9);
    rd(2, 0, v); chk("t3_txn", v, 3);
    rd(2, 1, v); chk("t3_last", v, 9);
    rd(2, 2, v); chk("t3_min", v, 2);
    rd(2, 3, v); chk("t3_max", v, 9);
    clear = 1'b1; tick(); clear = 1'b0;
    rd(2, 0, v); chk("t3_clr_txn", v, 0);
    rd(2, 2, v); chk("t3_clr_min", v, 32'hFFFF_FFFF);
    rd(0, 3, v); chk("t3_clr_max_ch0", v, 0);

    // timeout at the 16th busy cycle
    ch_ap_start[0] = 1'b1;
    tick();
    ch_ap_start[0] = 1'b0;
    repeat (15) tick();
    chk("t4_to_before", 32'(timeout[0]), 0);
    tick();
    chk("t4_to_set", 32'(timeout[0]), 1);
    chk("t4_busy_set", 32'(busy[0]), 1);
    repeat (4) tick();
    chk("t4_busy_hold", 32'(busy[0]), 1);
    ch_ap_done[0] = 1'b1; tick(); ch_ap_done[0] = 1'b0;
    rd(0, 1, v); chk("t4_last", v, 21);
    rd(0, 5, v); chk("t4_flags", v, 2);

    // protocol errors, zero-latency transaction
    ch_ap_done[3] = 1'b1; tick(); ch_ap_done[3] = 1'b0;
    chk("t5_pe_done", 32'(proto_err[3]), 1);
    rd(3, 0, v); chk("t5_txn_unch", v, 0);
    ch_ap_start[3] = 1'b1; ch_ap_done[3] = 1'b1; tick();
    ch_ap_start[3] = 1'b0; ch_ap_done[3] = 1'b0;
    rd(3, 0, v); chk("t5_txn0", v, 1);
    rd(3, 1, v); chk("t5_last0", v, 0);
    ch_ap_ready[2] = 1'b1; tick(); ch_ap_ready[2] = 1'b0;
    chk("t5_pe_vec", 32'(proto_err), 32'hC);
    chk("t5_to_vec", 32'(timeout), 32'h1);
    rd(3, 5, v); chk("t5_flags3", v, 4);
    rd(0, 6, v); chk("t5_field6", v, 0);

    // a record coinciding with clear is dropped
    clear = 1'b1; ch_ap_start[3] = 1'b1; ch_ap_done[3] = 1'b1; tick();
    clear = 1'b0; ch_ap_start[3] = 1'b0; ch_ap_done[3] = 1'b0;
    rd(3, 0, v); chk("t5_clr_txn", v, 0);
    chk("t5_clr_pe", 32'(proto_err), 0);
    chk("t5_clr_to", 32'(timeout), 0);

    // finish with staggered dones, then reset mid-run
    finish = 1'b1; tick(); finish = 1'b0;
    ch_ap_start = 4'hF; tick(); ch_ap_start = '0;
    chk("t6_all_busy", 32'(busy), 32'hF);
    chk("t6_not_idle", 32'(all_idle), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      ch_ap_done[c] = 1'b1; tick(); ch_ap_done[c] = 1'b0;
      if (c < 3) chk("t6_fin_early", 32'(finished), 0);
    end
    chk("t6_idle_now", 32'(all_idle), 1);
    chk("t6_fin_lag", 32'(finished), 0);
    tick();
    chk("t6_fin_rise", 32'(finished), 1);
    ch_ap_start[0] = 1'b1; tick(); ch_ap_start[0] = 1'b0; tick();
    reset = 1'b0; #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_idle", 32'(all_idle), 1);
    chk("t6_rst_fin", 32'(finished), 0);
    chk("t6_rst_rd", rd_data, 0);
    tick();
    chk("t6_rst_hold", 32'(busy), 0);
    reset = 1'b1;
    rd(0, 0, v); chk("t6_rst_txn", v, 0);
    rd(0, 2, v); chk("t6_rst_min", v, 32'hFFFF_FFFF);
    chk("t6_fin_cleared", 32'(finished), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
